// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the RX buffer writer and its slot ring.
package eth_rx_pkg;

  localparam int unsigned BUF_BYTES = 4096;
  localparam int unsigned MEM_AW    = 11;
  localparam int unsigned LEN_W     = 11;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } rx_wr_state_e;

  typedef struct packed {
    logic             slot;
    logic [LEN_W-1:0] len;
  } rx_desc_t;

endpackage

// File: rtl/eth_rx_slot_ring.sv
// Frame-slot ring: write/read pointers, occupancy and per-slot committed lengths.
module eth_rx_slot_ring
  import eth_rx_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit,
  input  logic [LEN_W-1:0] commit_len,
  input  logic             ack,
  output logic             wr_slot,
  output logic             full,
  output logic             valid,
  output rx_desc_t         desc
);

  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       used;
  logic             pend;
  logic             take;
  logic [1:0]       occ;
  logic [LEN_W-1:0] len_q [0:NUM_SLOTS-1];

  assign take = ack & (used != 2'd0);
  // A commit becomes visible in `used` one cycle late; count it as occupied meanwhile.
  assign occ  = used + {1'b0, pend};
  assign full = occ >= 2'(NUM_SLOTS);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      used   <= 2'd0;
      pend   <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      pend <= commit;
      if (commit) begin
        len_q[wr_ptr] <= commit_len;
        wr_ptr        <= (NUM_SLOTS == 2) ? ~wr_ptr : 1'b0;
      end
      if (take) rd_ptr <= (NUM_SLOTS == 2) ? ~rd_ptr : 1'b0;
      used <= used + {1'b0, pend} - {1'b0, take};
    end
  end

  assign wr_slot   = wr_ptr;
  assign valid     = used != 2'd0;
  assign desc.slot = rd_ptr;
  assign desc.len  = len_q[rd_ptr];

endmodule

// File: rtl/eth_rx_buf_writer.sv
// Byte-stream RX frame writer into port A of the widening packet buffer.
// ETH_RX_FCS_STRIP_EN: committed length excludes the 4-byte FCS.
module eth_rx_buf_writer
  import eth_rx_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned MAX_LEN   = 1536,
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  input  logic              s_tuser,
  output logic              s_tready,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              rx_valid,
  output logic              rx_slot,
  output logic [LEN_W-1:0]  rx_len,
  input  logic              rx_ack,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);

  rx_wr_state_e     state, state_n;
  logic [11:0]      off, off_n, len_n;
  logic             beat, wr, commit, drop;
  logic             full, wr_slot;
  logic [MEM_AW-1:0] wr_addr;
  logic [LEN_W-1:0] commit_len;
  rx_desc_t         desc;

  assign beat  = s_tvalid & s_tready;
  assign len_n = off + 12'd1;

  always_comb begin
    if (NUM_SLOTS == 2) wr_addr = {wr_slot, off[10:1]};
    else                wr_addr = off[11:1];
  end

`ifdef ETH_RX_FCS_STRIP_EN
  assign commit_len = len_n[LEN_W-1:0] - LEN_W'(4);
`else
  assign commit_len = len_n[LEN_W-1:0];
`endif

  always_comb begin
    state_n = state;
    off_n   = off;
    wr      = 1'b0;
    commit  = 1'b0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (beat) begin
          // A lone tlast beat is a runt and never claims a slot.
          if (s_tlast) begin
            drop = 1'b1;
          end else if (full) begin
            state_n = DROP;
          end else begin
            state_n = RECV;
            wr      = 1'b1;
            off_n   = 12'd1;
          end
        end
      end
      RECV: begin
        if (beat) begin
          if (len_n > MAX_L) begin
            if (s_tlast) begin
              drop    = 1'b1;
              state_n = IDLE;
              off_n   = '0;
            end else begin
              state_n = DROP;
            end
          end else begin
            wr    = 1'b1;
            off_n = len_n;
            if (s_tlast) begin
              state_n = IDLE;
              off_n   = '0;
              if (!s_tuser && len_n >= MIN_L) commit = 1'b1;
              else                            drop   = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (beat && s_tlast) begin
          drop    = 1'b1;
          state_n = IDLE;
          off_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        off_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      off       <= '0;
      s_tready  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state    <= state_n;
      off      <= off_n;
      s_tready <= 1'b1;
      mem_en   <= wr;
      mem_we   <= wr ? (off[0] ? 2'b10 : 2'b01) : 2'b00;
      if (wr) begin
        mem_addr <= wr_addr;
        mem_din  <= {s_tdata, s_tdata};
      end
      if (commit && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
      if (drop && drop_cnt != '1)    drop_cnt  <= drop_cnt + CNT_W'(1);
    end
  end

  eth_rx_slot_ring #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .commit    (commit),
    .commit_len(commit_len),
    .ack       (rx_ack),
    .wr_slot   (wr_slot),
    .full      (full),
    .valid     (rx_valid),
    .desc      (desc)
  );

  assign rx_slot = desc.slot;
  assign rx_len  = desc.len;

endmodule

// File: tb/tb_eth_rx_buf_writer.sv
// Scoreboard bench for eth_rx_buf_writer: expected writes/descriptors queued by stimulus, checked by monitor.
module tb_eth_rx_buf_writer;

  localparam int unsigned NS   = 2;
  localparam int unsigned MAXL = 1536;
  localparam int unsigned MINL = 64;
  localparam int unsigned CW   = 16;
`ifdef ETH_RX_FCS_STRIP_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif

  typedef struct packed {
    logic [10:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
  } wr_t;

  typedef struct packed {
    logic        slot;
    logic [10:0] len;
  } desc_t;

  logic          clk, rst;
  logic [7:0]    s_tdata;
  logic          s_tvalid, s_tlast, s_tuser, s_tready;
  logic          mem_en;
  logic [1:0]    mem_we;
  logic [10:0]   mem_addr;
  logic [15:0]   mem_din;
  logic          rx_valid, rx_slot, rx_ack;
  logic [10:0]   rx_len;
  logic [CW-1:0] frame_cnt, drop_cnt;

  eth_rx_buf_writer #(
    .NUM_SLOTS(NS),
    .MAX_LEN  (MAXL),
    .MIN_LEN  (MINL),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .s_tready (s_tready),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .rx_valid (rx_valid),
    .rx_slot  (rx_slot),
    .rx_len   (rx_len),
    .rx_ack   (rx_ack),
    .frame_cnt(frame_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_t   exp_wr[$];
  desc_t exp_desc[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    wptr = 0, mcnt = 0, e_frames = 0, e_drops = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every port-A write and every accepted descriptor must match the queue head.
  always @(negedge clk) begin
    wr_t   w;
    desc_t d;
    if (mem_en === 1'b1) begin
      w = '{addr: mem_addr, we: mem_we, din: mem_din};
      if (exp_wr.size() == 0) check("unexpected_write", int'(w), -1);
      else check("mem_write", int'(w), int'(exp_wr.pop_front()));
    end
    if (rx_valid === 1'b1 && rx_ack === 1'b1) begin
      d = '{slot: rx_slot, len: rx_len};
      if (exp_desc.size() == 0) check("unexpected_desc", int'(d), -1);
      else check("descriptor", int'(d), int'(exp_desc.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit err);
    bit          full;
    logic [7:0]  b;
    logic [11:0] i12;
    full = (mcnt >= int'(NS));
    for (int i = 0; i < n; i++) begin
      b   = 8'(i * 7 + n);
      i12 = 12'(i);
      if (!full && n > 1 && i < int'(MAXL))
        exp_wr.push_back('{addr: {1'(wptr), i12[10:1]},
                           we: (i12[0] ? 2'b10 : 2'b01), din: {b, b}});
      s_tvalid = 1'b1;
      s_tdata  = b;
      s_tlast  = (i == n - 1);
      s_tuser  = err && (i == n - 1);
      @(posedge clk); #1;
    end
    if (!full && !err && n >= int'(MINL) && n <= int'(MAXL)) begin
      exp_desc.push_back('{slot: 1'(wptr), len: 11'(n - FCS)});
      wptr = (wptr + 1) % NS;
      mcnt++;
      e_frames++;
    end else begin
      e_drops++;
    end
  endtask

  task automatic do_ack();
    check("ack_valid", int'(rx_valid), 1);
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    mcnt--;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rx_ack = 1'b0; s_tdata = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", int'(s_tready), 0);
    check("rst_mem_en", int'(mem_en), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("tready_after_rst", int'(s_tready), 1);

    // Errored frame: written but dropped
    send_frame(100, 1'b1);
    idle();
    settle();
    check("err_drop_cnt", int'(drop_cnt), e_drops);
    check("err_rx_valid", int'(rx_valid), 0);
    check("err_frame_cnt", int'(frame_cnt), 0);

    // Good 64-byte frame into slot 0, rx_valid two cycles after tlast
    send_frame(64, 1'b0);
    idle();
    check("rxv_after_1", int'(rx_valid), 0);
    @(posedge clk); #1;
    check("rxv_after_2", int'(rx_valid), 1);
    check("good_slot", int'(rx_slot), 0);
    check("good_len", int'(rx_len), 64 - FCS);
    check("good_frame_cnt", int'(frame_cnt), 1);
    do_ack();
    check("rxv_after_ack", int'(rx_valid), 0);

    // Runt then oversize, back to back
    send_frame(40, 1'b0);
    send_frame(1600, 1'b0);
    idle();
    settle();
    check("runt_over_drop_cnt", int'(drop_cnt), e_drops);
    check("runt_over_frame_cnt", int'(frame_cnt), e_frames);
    check("runt_over_valid", int'(rx_valid), 0);

    // Commit into one slot in the same cycle the other slot is acked
    send_frame(64, 1'b0);
    idle();
    settle();
    send_frame(64, 1'b0);
    idle();
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    mcnt--;
    check("simul_valid", int'(rx_valid), 1);
    check("simul_slot", int'(rx_slot), wptr ^ 1);
    check("simul_len", int'(rx_len), 64 - FCS);
    @(posedge clk); #1;
    check("simul_valid_hold", int'(rx_valid), 1);
    do_ack();
    check("simul_drained", int'(rx_valid), 0);
    check("simul_frame_cnt", int'(frame_cnt), e_frames);

    // Reset mid-frame after 30 bytes
    for (int i = 0; i < 30; i++) begin
      logic [7:0]  b;
      logic [11:0] i12;
      b   = 8'(i + 8'h40);
      i12 = 12'(i);
      exp_wr.push_back('{addr: {1'(wptr), i12[10:1]},
                         we: (i12[0] ? 2'b10 : 2'b01), din: {b, b}});
      s_tvalid = 1'b1;
      s_tdata  = b;
      s_tlast  = 1'b0;
      @(posedge clk); #1;
    end
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_tready", int'(s_tready), 0);
    check("mrst_mem_en", int'(mem_en), 0);
    check("mrst_mem_we", int'(mem_we), 0);
    check("mrst_mem_addr", int'(mem_addr), 0);
    check("mrst_mem_din", int'(mem_din), 0);
    check("mrst_rx_valid", int'(rx_valid), 0);
    check("mrst_rx_slot", int'(rx_slot), 0);
    check("mrst_rx_len", int'(rx_len), 0);
    check("mrst_frame_cnt", int'(frame_cnt), 0);
    check("mrst_drop_cnt", int'(drop_cnt), 0);
    rst = 1'b0;
    wptr = 0; mcnt = 0; e_frames = 0; e_drops = 0;
    @(posedge clk); #1;

    // Three back-to-back frames: two slots fill, third dropped
    send_frame(64, 1'b0);
    send_frame(64, 1'b0);
    send_frame(64, 1'b0);
    idle();
    settle();
    check("b2b_frame_cnt", int'(frame_cnt), 2);
    check("b2b_drop_cnt", int'(drop_cnt), 1);
    check("b2b_first_slot", int'(rx_slot), 0);
    do_ack();
    check("b2b_second_slot", int'(rx_slot), 1);
    do_ack();
    check("b2b_drained", int'(rx_valid), 0);

    repeat (4) @(posedge clk);
    #1;
    check("writes_outstanding", exp_wr.size(), 0);
    check("descs_outstanding", exp_desc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
